// File: rtl/bitstream_page_buffer_pkg.sv
// Shared definitions for the bitstream page buffer: default geometry, pad
// value and the write-side / read-side state encodings.
package bitstream_page_buffer_pkg;

    localparam int         PAGE_SIZE_LOG2_DEF = 8;      // 256-byte flash page
    localparam int         PAGE_CNT_LOG2_DEF  = 2;      // 4 pages buffered
    localparam int         BS_DATA_W          = 8;      // bitstream byte width
    localparam logic [7:0] PAD_BYTE_DEF       = 8'hFF;  // erased-flash value

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_FILL = 2'd1,
        W_PAD  = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_READ = 1'b1
    } rd_state_t;

endpackage

// File: rtl/bitstream_page_buffer_ram.sv
// Simple dual-port page RAM: one write port, one registered read port.
// No reset on the array or read register so it maps onto block RAM.
module bs_page_ram
    import bitstream_page_buffer_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = BS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Write port.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read port: data appears one cycle after the enabled address.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/bitstream_page_buffer.sv
// Bitstream page buffer: collects bytes from the UART stage, cuts them into
// flash pages (padding the final partial page) and serves whole pages to the
// SPI flash write engine.
module bitstream_page_buffer
    import bitstream_page_buffer_pkg::*;
#(
    parameter int         PAGE_SIZE_LOG2 = PAGE_SIZE_LOG2_DEF,
    parameter int         PAGE_CNT_LOG2  = PAGE_CNT_LOG2_DEF,
    parameter logic [7:0] PAD_BYTE       = PAD_BYTE_DEF
) (
    input  logic                     sys_clk_25m,
    input  logic                     sys_rst_n,
    input  logic                     wr_start,
    input  logic [7:0]               wr_data,
    input  logic                     wr_valid,
    input  logic                     wr_last,
    output logic                     wr_ready,
    output logic                     wr_afull,
    output logic                     overflow_err,
    output logic [PAGE_CNT_LOG2:0]   pages_avail,
    input  logic                     bitstream_fifo_rd_req,
    output logic                     bitstream_fifo_rd_rdy,
    output logic [7:0]               bitstream_data,
    output logic                     bitstream_valid,
    output logic                     bitstream_eop
);

    localparam int AW  = PAGE_SIZE_LOG2 + PAGE_CNT_LOG2;
    localparam int PCW = PAGE_CNT_LOG2 + 1;
    localparam logic [PCW-1:0]            PAGES_FULL   = {1'b1, {PAGE_CNT_LOG2{1'b0}}};
    localparam logic [PCW-1:0]            PAGES_ONE    = {{PAGE_CNT_LOG2{1'b0}}, 1'b1};
    localparam logic [PAGE_SIZE_LOG2-1:0] OFS_LAST     = {PAGE_SIZE_LOG2{1'b1}};
    localparam logic [AW:0]               AFULL_THRESH = {1'b0, {PAGE_CNT_LOG2{1'b1}}, {PAGE_SIZE_LOG2{1'b0}}};

    wr_state_t                  r_wr_state, w_wr_state_nxt;
    rd_state_t                  r_rd_state, w_rd_state_nxt;
    logic [AW-1:0]              r_wr_ptr;
    logic [PAGE_CNT_LOG2-1:0]   r_rd_page;
    logic [PAGE_SIZE_LOG2-1:0]  r_rd_cnt;
    logic [PCW-1:0]             r_pages_avail;
    logic [PAGE_CNT_LOG2-1:0]   r_last_page_id;
    logic                       r_last_valid;
    logic                       r_overflow;
    logic                       r_rd_pend, r_rd_pend_eop;
    logic [7:0]                 r_data_out;
    logic                       r_valid_out, r_eop_out;

    logic                       w_wr_ready, w_ram_we, w_page_done, w_final_close, w_overflow_set;
    logic [7:0]                 w_ram_wdata, w_ram_rdata;
    logic                       w_ram_re, w_page_read_done, w_rd_eop_issue, w_rd_rdy;
    logic [PAGE_SIZE_LOG2-1:0]  w_wr_ofs;
    logic [AW:0]                w_used;

    assign w_wr_ofs = r_wr_ptr[PAGE_SIZE_LOG2-1:0];
    // Bytes held = completed pages (including one being read) plus the open page fill.
    assign w_used   = {r_pages_avail, {PAGE_SIZE_LOG2{1'b0}}} + {{PCW{1'b0}}, w_wr_ofs};
    assign w_rd_rdy = (r_rd_state == R_IDLE) && (r_pages_avail != {PCW{1'b0}});

    // Write FSM next state, RAM write strobe and page-close events.
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_ready     = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_wdata    = wr_data;
        w_page_done    = 1'b0;
        w_final_close  = 1'b0;
        w_overflow_set = 1'b0;
        case (r_wr_state)
            W_FILL: begin
                w_wr_ready = (r_pages_avail != PAGES_FULL);
                if (wr_valid && w_wr_ready) begin
                    w_ram_we    = 1'b1;
                    w_page_done = (w_wr_ofs == OFS_LAST);
                    if (wr_last && w_page_done) begin
                        w_final_close  = 1'b1;
                        w_wr_state_nxt = W_IDLE;
                    end else if (wr_last) begin
                        w_wr_state_nxt = W_PAD;
                    end else begin
                        w_wr_state_nxt = W_FILL;
                    end
                end else begin
                    w_wr_state_nxt = W_FILL;
                end
            end
            W_PAD: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = PAD_BYTE;
                w_page_done = (w_wr_ofs == OFS_LAST);
                if (w_page_done) begin
                    w_final_close  = 1'b1;
                    w_wr_state_nxt = W_IDLE;
                end else begin
                    w_wr_state_nxt = W_PAD;
                end
            end
            W_IDLE: begin
                w_wr_state_nxt = W_IDLE;
            end
            default: begin
                w_wr_state_nxt = W_IDLE;
            end
        endcase
        // A new bitstream discards whatever the current cycle would have written.
        if (wr_start) begin
            w_wr_state_nxt = W_FILL;
            w_ram_we       = 1'b0;
            w_page_done    = 1'b0;
            w_final_close  = 1'b0;
            w_overflow_set = 1'b0;
        end else begin
            w_overflow_set = wr_valid && !w_wr_ready;
        end
    end

    // Read FSM next state, RAM read strobe and end-of-page event.
    always_comb begin
        w_rd_state_nxt   = r_rd_state;
        w_ram_re         = 1'b0;
        w_page_read_done = 1'b0;
        w_rd_eop_issue   = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (bitstream_fifo_rd_req && w_rd_rdy) begin
                    w_rd_state_nxt = R_READ;
                end else begin
                    w_rd_state_nxt = R_IDLE;
                end
            end
            R_READ: begin
                w_ram_re = 1'b1;
                if (r_rd_cnt == OFS_LAST) begin
                    w_page_read_done = 1'b1;
                    w_rd_state_nxt   = R_IDLE;
                end else begin
                    w_rd_state_nxt   = R_READ;
                end
            end
            default: begin
                w_rd_state_nxt = R_IDLE;
            end
        endcase
        // wr_start aborts a read in flight; eop is only flagged on the final page.
        if (wr_start) begin
            w_rd_state_nxt   = R_IDLE;
            w_ram_re         = 1'b0;
            w_page_read_done = 1'b0;
        end else begin
            w_rd_eop_issue = w_page_read_done && r_last_valid && (r_rd_page == r_last_page_id);
        end
    end

    // Write-side state, pointer, page accounting and sticky flags.
    always_ff @(posedge sys_clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_state     <= W_FILL;
            r_wr_ptr       <= {AW{1'b0}};
            r_pages_avail  <= {PCW{1'b0}};
            r_last_page_id <= {PAGE_CNT_LOG2{1'b0}};
            r_last_valid   <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (wr_start) begin
            r_wr_state     <= W_FILL;
            r_wr_ptr       <= {AW{1'b0}};
            r_pages_avail  <= {PCW{1'b0}};
            r_last_page_id <= {PAGE_CNT_LOG2{1'b0}};
            r_last_valid   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            if (w_ram_we) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_page_done, w_page_read_done})
                2'b10:   r_pages_avail <= r_pages_avail + PAGES_ONE;
                2'b01:   r_pages_avail <= r_pages_avail - PAGES_ONE;
                default: r_pages_avail <= r_pages_avail;
            endcase
            if (w_final_close) begin
                r_last_page_id <= r_wr_ptr[AW-1:PAGE_SIZE_LOG2];
                r_last_valid   <= 1'b1;
            end
            if (w_overflow_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Read-side state, page index and byte counter.
    always_ff @(posedge sys_clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_page  <= {PAGE_CNT_LOG2{1'b0}};
            r_rd_cnt   <= {PAGE_SIZE_LOG2{1'b0}};
        end else if (wr_start) begin
            r_rd_state <= R_IDLE;
            r_rd_page  <= {PAGE_CNT_LOG2{1'b0}};
            r_rd_cnt   <= {PAGE_SIZE_LOG2{1'b0}};
        end else begin
            r_rd_state <= w_rd_state_nxt;
            if (w_ram_re) begin
                r_rd_cnt <= r_rd_cnt + {{(PAGE_SIZE_LOG2-1){1'b0}}, 1'b1};
            end
            if (w_page_read_done) begin
                r_rd_page <= r_rd_page + {{(PAGE_CNT_LOG2-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output pipeline aligned with the RAM read latency; data is zero when not valid.
    always_ff @(posedge sys_clk_25m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rd_pend     <= 1'b0;
            r_rd_pend_eop <= 1'b0;
            r_data_out    <= 8'h00;
            r_valid_out   <= 1'b0;
            r_eop_out     <= 1'b0;
        end else if (wr_start) begin
            r_rd_pend     <= 1'b0;
            r_rd_pend_eop <= 1'b0;
            r_data_out    <= 8'h00;
            r_valid_out   <= 1'b0;
            r_eop_out     <= 1'b0;
        end else begin
            r_rd_pend     <= w_ram_re;
            r_rd_pend_eop <= w_rd_eop_issue;
            r_data_out    <= r_rd_pend ? w_ram_rdata : 8'h00;
            r_valid_out   <= r_rd_pend;
            r_eop_out     <= r_rd_pend_eop;
        end
    end

    bs_page_ram #(
        .ADDR_W (AW),
        .DATA_W (8)
    ) u_ram (
        .i_clk   (sys_clk_25m),
        .i_we    (w_ram_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr ({r_rd_page, r_rd_cnt}),
        .o_rdata (w_ram_rdata)
    );

    assign wr_ready              = w_wr_ready;
    assign wr_afull              = (w_used > AFULL_THRESH);
    assign overflow_err          = r_overflow;
    assign pages_avail           = r_pages_avail;
    assign bitstream_fifo_rd_rdy = w_rd_rdy;
    assign bitstream_data        = r_data_out;
    assign bitstream_valid       = r_valid_out;
    assign bitstream_eop         = r_eop_out;

endmodule
